// File: rtl/serial_subtractor_if.sv
// Handshake/operand bundle for serial_subtractor.
// OVF exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             OVF;

  modport master (output start, A, B, input busy, done, Diff, Bout, OVF);
  modport slave  (input start, A, B, output busy, done, Diff, Bout, OVF);
`else
  modport master (output start, A, B, input busy, done, Diff, Bout);
  modport slave  (input start, A, B, output busy, done, Diff, Bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, diff_q, r_nxt;
  logic [WIDTH-2:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             borrow, bout_q, d, br, last;

  assign d     = a_sh[0] ^ b_sh[0] ^ borrow;
  assign br    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
  assign last  = (cnt == CW'(WIDTH - 1));
  // new bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0
  assign r_nxt = {d, r_sh};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          a_sh   <= bus.A;
          b_sh   <= bus.B;
          borrow <= 1'b0;
          cnt    <= '0;
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          r_sh   <= r_nxt[WIDTH-1:1];
          borrow <= br;
          if (last) begin
            diff_q <= r_nxt;
            bout_q <= br;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  logic a_sgn, b_sgn, ovf_q;

  // d on the final edge is the result sign bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sgn <= 1'b0;
      b_sgn <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      a_sgn <= bus.A[WIDTH-1];
      b_sgn <= bus.B[WIDTH-1];
    end else if (state_q == RUN && last) begin
      ovf_q <= (a_sgn != b_sgn) && (d != a_sgn);
    end
  end

  assign bus.OVF = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle-level reference model plus literal checks.
module tb_serial_subtractor;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  serial_subtractor_if #(.WIDTH(W)) bus();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] sub_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic logic ovf_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, dd;
    sa = (int'(a) >= 2**(W-1)) ? int'(a) - 2**W : int'(a);
    sb = (int'(b) >= 2**(W-1)) ? int'(b) - 2**W : int'(b);
    dd = sa - sb;
    return (dd < -(2**(W-1))) || (dd > 2**(W-1) - 1);
  endfunction

  // Reference: phase counts edges since acceptance; result appears WIDTH edges after.
  int           phase = 0;
  logic [W-1:0] pa = '0, pb = '0, m_diff = '0;
  logic         m_bout = 1'b0, m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= 0;
      m_diff <= '0;
      m_bout <= 1'b0;
      m_ovf  <= 1'b0;
    end else if (phase == 0) begin
      if (bus.start) begin
        phase <= 1;
        pa    <= bus.A;
        pb    <= bus.B;
      end
    end else if (phase == W) begin
      {m_bout, m_diff} <= sub_ref(pa, pb);
      m_ovf <= ovf_ref(pa, pb);
      phase <= W + 1;
    end else if (phase == W + 1) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  always @(negedge clk) begin
`ifdef SERIAL_SUB_OVF_EN
    chk("outs{busy,done,bout,ovf,diff}",
        {bus.busy, bus.done, bus.Bout, bus.OVF, bus.Diff},
        {phase != 0, phase == W + 1, m_bout, m_ovf, m_diff});
`else
    chk("outs{busy,done,bout,diff}",
        {bus.busy, bus.done, bus.Bout, bus.Diff},
        {phase != 0, phase == W + 1, m_bout, m_diff});
`endif
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); #1;
    bus.start = 1'b1; bus.A = a; bus.B = b;
    @(negedge clk); #1;
    bus.start = 1'b0; bus.A = W'($urandom); bus.B = W'($urandom);
  endtask

  // returns just after the negedge where done is seen
  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_timeout", 64'd0, 64'd1);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(a, b);
    wait_done();
  endtask

  initial begin
    int nb, nd, dpos;
    bus.start = 1'b0; bus.A = '0; bus.B = '0;
    #12;
    chk("reset_busy", bus.busy, 0);
    chk("reset_diff", {bus.done, bus.Bout, bus.Diff}, 0);
    @(negedge clk); #1 rst_n = 1'b1;

    // 9-3: busy five cycles, done on the fifth negedge after accept
    @(negedge clk); #1;
    bus.start = 1'b1; bus.A = 4'd9; bus.B = 4'd3;
    nb = 0; nd = 0; dpos = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin #1 bus.start = 1'b0; bus.A = 4'd0; bus.B = 4'd0; end
      if (bus.busy) nb++;
      if (bus.done) begin nd++; dpos = i; chk("t1_diff", {bus.Bout, bus.Diff}, {1'b0, 4'd6}); end
    end
    chk("t1_busy_cycles", nb, 5);
    chk("t1_done_pulses", nd, 1);
    chk("t1_done_pos", dpos, 5);

    run_op(4'd3, 4'd9);
    chk("t2_diff", {bus.Bout, bus.Diff}, {1'b1, 4'hA});
    start_op(4'd5, 4'd5);
    chk("t2_hold", {bus.Bout, bus.Diff}, {1'b1, 4'hA});
    wait_done();
    chk("t2_eq", {bus.Bout, bus.Diff}, 5'd0);

    run_op(4'd0, 4'd15);
    chk("bnd_0_minus_15", {bus.Bout, bus.Diff}, {1'b1, 4'd1});

    // start held high with A/B moving every cycle
    @(negedge clk); #1 bus.start = 1'b1;
    nd = 0;
    for (int i = 0; i < 8 * (W + 2); i++) begin
      @(negedge clk);
      if (bus.done) nd++;
      #1 bus.A = W'($urandom); bus.B = W'($urandom);
    end
    bus.start = 1'b0;
    chk("t3_done_count", nd, 8);
    repeat (W + 3) @(negedge clk);

    // async reset on the second RUN cycle
    run_op(4'd12, 4'd5);
    chk("t4_pre", {bus.Bout, bus.Diff}, {1'b0, 4'd7});
    start_op(4'd9, 4'd3);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t4_async_clr", {bus.busy, bus.done, bus.Bout, bus.Diff}, 7'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    chk("t4_no_done", bus.done, 0);
    run_op(4'd15, 4'd1);
    chk("t4_after", {bus.Bout, bus.Diff}, {1'b0, 4'hE});

`ifdef SERIAL_SUB_OVF_EN
    run_op(4'd7, 4'd8);
    chk("t5_ovf1", {bus.Bout, bus.OVF, bus.Diff}, {1'b1, 1'b1, 4'hF});
    run_op(4'd2, 4'd1);
    chk("t5_ovf0", bus.OVF, 0);
`endif

    // exhaustive pairs, checked cycle by cycle against the model
    for (int a = 0; a < 2**W; a++)
      for (int b = 0; b < 2**W; b++)
        run_op(W'(a), W'(b));

    // random start/operand traffic including starts during RUN/DONE
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      bus.start = ($urandom_range(0, 3) == 0);
      bus.A = W'($urandom);
      bus.B = W'($urandom);
    end
    bus.start = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
